// File: rtl/ifetch_pkg.sv
// Shared fetch definitions: reset PC default, NOP encoding
// and the {pc, inst} layout of a prefetch buffer entry.
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    localparam int PC_HI   = 63;
    localparam int PC_LO   = 32;
    localparam int INST_HI = 31;
    localparam int INST_LO = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [63:0] pack_entry(
        input logic [31:0] pc,
        input logic [31:0] inst
    );
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_buf.sv
// Small synchronous FIFO holding fetched {pc, inst} entries.
// Flush clears it and overrides push and pop.
module fetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEP = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [63:0]             wdata,
    output logic [$clog2(DEP):0]    count,
    output logic                    full,
    output logic                    empty,
    output logic [63:0]             head
);

    localparam int PW = (DEP > 1) ? $clog2(DEP) : 1;
    localparam logic [PW:0] DEP_C = (PW + 1)'(DEP);

    logic [63:0] mem_q [DEP];
    logic [63:0] mem_d [DEP];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic do_push, do_pop;

    assign do_push = push & ~flush;
    assign do_pop  = pop & ~flush & (cnt_q != '0);

    // Next-state for pointers, count and storage.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d = wr_q + PW'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEP; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign full  = (cnt_q == DEP_C);
    assign empty = (cnt_q == '0);
    assign head  = empty ? 64'd0 : mem_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: owns the PC, addresses program memory,
// buffers fetched words and hands {pc, inst} to decode.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int          ADDR_WID = 30,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          BUF_DEP  = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [ADDR_WID-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    output logic                if_valid,
    input  logic                if_ready,
    output logic [31:0]         if_inst,
    output logic [31:0]         if_pc,
    input  logic                redir_valid,
    input  logic [31:0]         redir_target,
    output logic                misalign_err
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic        push, pop;
    logic        buf_full, buf_empty;
    logic [$clog2(BUF_DEP):0] buf_count;
    logic [63:0] head;

    assign pop  = if_valid & if_ready;
    assign push = ~redir_valid & (~buf_full | pop);

    fetch_buf #(
        .DEP   (BUF_DEP)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .wdata (pack_entry(pc_q, imem_rdata)),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty),
        .head  (head)
    );

    // PC update: redirect wins, otherwise advance on each push.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        if (redir_valid) begin
            pc_d       = {redir_target[31:2], 2'b00};
            misalign_d = |redir_target[1:0];
        end else if (push) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // PC and misalignment pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem_addr    = pc_q[ADDR_WID+1:2];
    assign if_valid     = ~buf_empty;
    assign if_pc        = head[PC_HI:PC_LO];
    assign if_inst      = head[INST_HI:INST_LO];
    assign misalign_err = misalign_q;

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch initiator for the single-issue core. It holds the PC and drives the word address to the asynchronous-read program memory (mem_prog). It captures the returned word into a small prefetch buffer and presents {pc, instruction} to decode over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and reload the PC.

Parameters:
ADDR_WID, 30, word-address width driven to program memory (32-2)
RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be 4-byte aligned
BUF_DEP, 2, prefetch buffer depth in entries; power of two, >=2

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_WID  word address to mem_prog.addr; equals pc_q[31:2]
imem_rdata  input  32  instruction word from mem_prog.rdata, valid combinationally in the same cycle
if_valid  output  1  buffer head holds a valid instruction
if_ready  input  1  decode accepts the head this cycle
if_inst  output  32  head instruction word
if_pc  output  32  byte address of head instruction
redir_valid  input  1  one-cycle redirect request (taken branch or jump)
redir_target  input  32  redirect byte address
misalign_err  output  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- Reset (asynchronous, immediate on rst=1): pc_q=RESET_PC, buffer empty (count=0, rd/wr pointers 0), if_valid=0, if_inst=0, if_pc=0, misalign_err=0. imem_addr=RESET_PC[31:2] during reset.
- imem_addr is purely combinational from pc_q; no memory latency, so the fetched word is written in the same cycle it is addressed.
- pop = if_valid & if_ready. push = !redir_valid & (count<BUF_DEP | pop). Full buffer with a simultaneous pop still pushes, so count is unchanged.
- On push: entry[wr] <= {pc_q, imem_rdata}; pc_q <= pc_q + 4 (32-bit wrap: 32'hFFFF_FFFC -> 0); wr advances modulo BUF_DEP.
- If push is not allowed (full with no pop): pc_q holds and imem_addr is stable.
- Redirect has highest priority. When redir_valid=1 at an edge:
  - buffer flushed (count=0, pointers 0); any pop in that cycle is discarded and is not treated as accepted;
  - pc_q <= {redir_target[31:2],2'b00};
  - no push in that cycle;
  - misalign_err <= |redir_target[1:0] for one cycle, otherwise 0.
- Redirect latency: if_valid=0 in the cycle after the redirect edge. The target instruction appears on if_inst/if_pc one cycle after that (2 edges after redir_valid is sampled).
- if_valid = (count!=0). if_inst/if_pc come from entry[rd], driven as registered storage through a mux with no combinational path from imem_rdata. if_inst and if_pc read 0 when the buffer is empty.
- Steady state with if_ready=1 continuously: one instruction per cycle, PCs incrementing by 4, no bubbles.
- Back-to-back redirects: each redirect restarts the fetch; only the last target is fetched.
- Reset asserted mid-stream: all state is cleared immediately; fetch resumes at RESET_PC on the first edge after rst deasserts.
- Legal redirect_target and RESET_PC values are byte addresses; bounds checking against memory depth is the memory's concern. Out-of-range words return whatever mem_prog returns.

Decomposition:
- Shared package/defines file ifetch_pkg.h: `RESET_PC default, `INST_NOP 32'h0000_0013, and the fetch-entry layout (PC_HI=63, PC_LO=32, INST_HI=31, INST_LO=0).
- Sub-module fetch_buf (BUF_DEP-entry synchronous FIFO with push/pop/flush, count, head outputs). Its flush overrides push and pop. The PC/redirect logic stays in ifetch_unit.

Test Plan:
1. Reset release, if_ready=1, memory words 0..3 = 32'h11,22,33,44 → if_valid rises after first edge; if_pc sequence 0,4,8,12 with if_inst 11,22,33,44, one per cycle.
2. if_ready=0 for 5 cycles from reset → buffer fills at 2 entries; imem_addr holds at 2 (pc=8); on if_ready=1, head pc=0 then 4 then 8 with no gaps.
3. Redirect to 32'h0000_0100 while buffer is full → next cycle if_valid=0; following cycle if_pc=32'h100, if_inst=mem[64]; stale pc=0/4 entries are never accepted.
4. Redirect to 32'h0000_0042 → misalign_err pulses 1 cycle; fetch resumes at 32'h40.
5. Redirect to 32'hFFFF_FFF8 with if_ready=1 → if_pc 32'hFFFF_FFF8, 32'hFFFF_FFFC, then 32'h0000_0000 (wrap).
6. rst pulsed asynchronously between edges during streaming → if_valid drops immediately and imem_addr=0; after release, first if_pc=RESET_PC.
